// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit sequencer: FSM states, byte framing
// constants and default conditioning depths.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int BITS_PER_BYTE       = 8;
  localparam int BIT_CNT_W           = $clog2(BITS_PER_BYTE + 1);
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_FILTER_LEN  = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one raw I2C line; the filtered level
// only follows the input after FILTER_LEN consecutive differing samples.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_f
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sample;

  // Idle I2C lines are high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_f <= 1'b1;
      cnt_q  <= '0;
    end else if (sample == line_f) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      line_f <= sample;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// Bus-facing front end: conditions SCL/SDA, detects START/STOP and frames
// each byte plus its ACK slot into strobes for the shift register and FSM.
module i2c_bit_sequencer
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_sample,
  output logic shift_en,
  output logic load,
  output logic byte_done,
  output logic first_byte,
  output logic ack_phase,
  output logic ack_valid,
  output logic ack_bit,
  output logic start_det,
  output logic stop_det,
  output logic busy
);

  localparam logic [BIT_CNT_W-1:0] BYTE_END = BIT_CNT_W'(BITS_PER_BYTE);

  logic scl_f, sda_f;
  logic scl_p, sda_p;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  state_t               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic shift_en_d, load_d, byte_done_d, first_byte_d, ack_phase_d;
  logic ack_valid_d, ack_bit_d, start_det_d, stop_det_d, busy_d;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_in(scl_in),
    .line_f (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_in(sda_in),
    .line_f (sda_f)
  );

  assign sda_sample = sda_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  // Requiring SCL high on both samples makes an SDA change coincident with
  // an SCL edge count as data, never as START/STOP.
  assign scl_rise   = scl_f & ~scl_p;
  assign scl_fall   = ~scl_f & scl_p;
  assign start_cond = sda_p & ~sda_f & scl_f & scl_p;
  assign stop_cond  = ~sda_p & sda_f & scl_f & scl_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_en   <= 1'b0;
      load       <= 1'b0;
      byte_done  <= 1'b0;
      first_byte <= 1'b0;
      ack_phase  <= 1'b0;
      ack_valid  <= 1'b0;
      ack_bit    <= 1'b1;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_en   <= shift_en_d;
      load       <= load_d;
      byte_done  <= byte_done_d;
      first_byte <= first_byte_d;
      ack_phase  <= ack_phase_d;
      ack_valid  <= ack_valid_d;
      ack_bit    <= ack_bit_d;
      start_det  <= start_det_d;
      stop_det   <= stop_det_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_en_d   = 1'b0;
    load_d       = 1'b0;
    byte_done_d  = 1'b0;
    ack_valid_d  = 1'b0;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    first_byte_d = first_byte;
    ack_phase_d  = ack_phase;
    ack_bit_d    = ack_bit;
    busy_d       = busy;

    if (start_cond) begin
      start_det_d  = 1'b1;
      busy_d       = 1'b1;
      first_byte_d = 1'b1;
      ack_phase_d  = 1'b0;
      bit_cnt_d    = '0;
      state_d      = DATA;
    end else if (stop_cond) begin
      stop_det_d   = 1'b1;
      busy_d       = 1'b0;
      first_byte_d = 1'b0;
      ack_phase_d  = 1'b0;
      bit_cnt_d    = '0;
      state_d      = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        DATA: begin
          // Delayed one clk behind the last shift so data_out has settled.
          byte_done_d = shift_en && (bit_cnt_q == BYTE_END);
          if (scl_rise && (bit_cnt_q < BYTE_END)) begin
            shift_en_d = 1'b1;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
          end else if (scl_fall && (bit_cnt_q == BYTE_END)) begin
            ack_phase_d = 1'b1;
            state_d     = ACK;
          end
        end
        ACK: begin
          if (scl_rise) begin
            ack_bit_d   = sda_f;
            ack_valid_d = 1'b1;
          end else if (scl_fall) begin
            load_d       = 1'b1;
            ack_phase_d  = 1'b0;
            first_byte_d = 1'b0;
            bit_cnt_d    = '0;
            state_d      = DATA;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Directed bench for i2c_bit_sequencer: drives raw SCL/SDA at clk/16 and
// checks strobes against hand-computed bus scenarios.
module tb_i2c_bit_sequencer;

  logic clk;
  logic rst_n;
  logic scl_raw;
  logic sda_raw;
  logic sda_sample, shift_en, load, byte_done, first_byte, ack_phase;
  logic ack_valid, ack_bit, start_det, stop_det, busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_shift_cyc = 0;
  int bd_delta = 0;
  int shift_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int bd_cnt = 0;
  int load_cnt = 0;
  int av_cnt = 0;
  logic [7:0] shift_data = 8'h00;
  logic bd_first = 1'b0;
  logic av_bit = 1'b1;
  logic av_phase = 1'b0;

  i2c_bit_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_raw),
    .sda_in    (sda_raw),
    .sda_sample(sda_sample),
    .shift_en  (shift_en),
    .load      (load),
    .byte_done (byte_done),
    .first_byte(first_byte),
    .ack_phase (ack_phase),
    .ack_valid (ack_valid),
    .ack_bit   (ack_bit),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc <= cyc + 1;
    if (shift_en) begin
      shift_cnt      <= shift_cnt + 1;
      shift_data     <= {shift_data[6:0], sda_sample};
      last_shift_cyc <= cyc;
    end
    if (byte_done) begin
      bd_cnt   <= bd_cnt + 1;
      bd_delta <= cyc - last_shift_cyc;
      bd_first <= first_byte;
    end
    if (ack_valid) begin
      av_cnt   <= av_cnt + 1;
      av_bit   <= ack_bit;
      av_phase <= ack_phase;
    end
    if (load)      load_cnt  <= load_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(4);
    sda_raw = b;
    wait_clk(4);
    scl_raw = 1'b1;
    wait_clk(8);
    scl_raw = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic bus_stop();
    wait_clk(4);
    sda_raw = 1'b0;
    wait_clk(4);
    scl_raw = 1'b1;
    wait_clk(8);
    sda_raw = 1'b1;
    wait_clk(8);
  endtask

  task automatic bus_rep_start();
    wait_clk(4);
    sda_raw = 1'b1;
    wait_clk(4);
    scl_raw = 1'b1;
    wait_clk(8);
    sda_raw = 1'b0;
    wait_clk(8);
    scl_raw = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    scl_raw = 1'b1;
    sda_raw = 1'b1;
    wait_clk(5);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy_held: got %b expected 0", busy);
    end
    rst_n = 1'b1;
    wait_clk(100);
    checks++;
    if ((shift_cnt + start_cnt + stop_cnt + bd_cnt + load_cnt + av_cnt) !== 0) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %0d pulses expected 0",
               shift_cnt + start_cnt + stop_cnt + bd_cnt + load_cnt + av_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (sda_sample !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_sda_sample: got %b expected 1", sda_sample);
    end
    checks++;
    if (ack_bit !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ack_bit: got %b expected 1", ack_bit);
    end
    checks++;
    if ({first_byte, ack_phase} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {first_byte, ack_phase});
    end
  endtask

  // START, address byte 0xA4, ACK; leaves SCL low after the ACK slot.
  task automatic test_first_byte();
    int s0, b0, a0, l0;
    s0 = shift_cnt; b0 = bd_cnt; a0 = av_cnt; l0 = load_cnt;
    sda_raw = 1'b0;
    wait_clk(5);
    checks++;
    if (start_det !== 1'b0) begin
      errors++; $display("[TB] FAIL start_early: got %b expected 0 at 5 clk", start_det);
    end
    wait_clk(1);
    checks++;
    if (start_det !== 1'b1) begin
      errors++; $display("[TB] FAIL start_latency: got %b expected 1 at 6 clk", start_det);
    end
    checks++;
    if ({busy, first_byte} !== 2'b11) begin
      errors++; $display("[TB] FAIL start_flags: got %b expected 11", {busy, first_byte});
    end
    wait_clk(2);
    scl_raw = 1'b0;
    send_byte(8'hA4);
    checks++;
    if (shift_cnt - s0 !== 8) begin
      errors++; $display("[TB] FAIL byte1_shifts: got %0d expected 8", shift_cnt - s0);
    end
    checks++;
    if (shift_data !== 8'hA4) begin
      errors++; $display("[TB] FAIL byte1_data: got %h expected a4", shift_data);
    end
    checks++;
    if (bd_cnt - b0 !== 1 || bd_delta !== 1 || bd_first !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byte1_done: got count %0d delay %0d first %b expected 1 1 1",
               bd_cnt - b0, bd_delta, bd_first);
    end
    send_bit(1'b0);
    checks++;
    if (av_cnt - a0 !== 1 || av_bit !== 1'b0 || av_phase !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byte1_ack: got count %0d bit %b phase %b expected 1 0 1",
               av_cnt - a0, av_bit, av_phase);
    end
    wait_clk(8);
    checks++;
    if (load_cnt - l0 !== 1) begin
      errors++; $display("[TB] FAIL byte1_load: got %0d expected 1", load_cnt - l0);
    end
    checks++;
    if ({first_byte, ack_phase, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL byte1_after_ack: got %b expected 001", {first_byte, ack_phase, busy});
    end
  endtask

  task automatic test_nack_stop();
    int b0, a0, p0, s1;
    b0 = bd_cnt; a0 = av_cnt; p0 = stop_cnt;
    send_byte(8'h3C);
    checks++;
    if (shift_data !== 8'h3C || bd_cnt - b0 !== 1 || bd_first !== 1'b0) begin
      errors++;
      $display("[TB] FAIL byte2: got data %h count %0d first %b expected 3c 1 0",
               shift_data, bd_cnt - b0, bd_first);
    end
    send_bit(1'b1);
    checks++;
    if (av_cnt - a0 !== 1 || av_bit !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byte2_nack: got count %0d bit %b expected 1 1", av_cnt - a0, av_bit);
    end
    bus_stop();
    checks++;
    if (stop_cnt - p0 !== 1) begin
      errors++; $display("[TB] FAIL stop_det: got %0d expected 1", stop_cnt - p0);
    end
    checks++;
    if ({busy, first_byte, ack_phase} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL stop_flags: got %b expected 000", {busy, first_byte, ack_phase});
    end
    s1 = shift_cnt;
    for (int i = 0; i < 4; i++) begin
      scl_raw = 1'b0;
      wait_clk(8);
      scl_raw = 1'b1;
      wait_clk(8);
    end
    wait_clk(8);
    checks++;
    if (shift_cnt - s1 !== 0) begin
      errors++; $display("[TB] FAIL idle_scl_shift: got %0d expected 0", shift_cnt - s1);
    end
  endtask

  task automatic test_glitch();
    int s0, st0, p0;
    s0 = shift_cnt; st0 = start_cnt; p0 = stop_cnt;
    sda_raw = 1'b0;
    wait_clk(2);
    sda_raw = 1'b1;
    wait_clk(12);
    scl_raw = 1'b0;
    wait_clk(2);
    scl_raw = 1'b1;
    wait_clk(20);
    checks++;
    if (start_cnt - st0 !== 0 || stop_cnt - p0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_cond: got start %0d stop %0d expected 0 0",
               start_cnt - st0, stop_cnt - p0);
    end
    checks++;
    if (shift_cnt - s0 !== 0) begin
      errors++; $display("[TB] FAIL glitch_shift: got %0d expected 0", shift_cnt - s0);
    end
    checks++;
    if ({busy, sda_sample} !== 2'b01) begin
      errors++; $display("[TB] FAIL glitch_outputs: got %b expected 01", {busy, sda_sample});
    end
  endtask

  task automatic test_repeated_start();
    int st0, b0, s0;
    sda_raw = 1'b0;
    wait_clk(8);
    scl_raw = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    st0 = start_cnt; b0 = bd_cnt;
    bus_rep_start();
    checks++;
    if (start_cnt - st0 !== 1) begin
      errors++; $display("[TB] FAIL rstart_det: got %0d expected 1", start_cnt - st0);
    end
    checks++;
    if (bd_cnt - b0 !== 0) begin
      errors++; $display("[TB] FAIL rstart_no_done: got %0d expected 0", bd_cnt - b0);
    end
    checks++;
    if ({busy, first_byte} !== 2'b11) begin
      errors++; $display("[TB] FAIL rstart_flags: got %b expected 11", {busy, first_byte});
    end
    s0 = shift_cnt;
    send_byte(8'hA4);
    send_bit(1'b0);
    checks++;
    if (shift_cnt - s0 !== 8 || bd_cnt - b0 !== 1 || shift_data !== 8'hA4) begin
      errors++;
      $display("[TB] FAIL rstart_byte: got shifts %0d done %0d data %h expected 8 1 a4",
               shift_cnt - s0, bd_cnt - b0, shift_data);
    end
    bus_stop();
  endtask

  task automatic test_reset_mid_transfer();
    int s0, st0;
    sda_raw = 1'b0;
    wait_clk(8);
    scl_raw = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    wait_clk(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, first_byte, ack_phase, shift_en, sda_sample, ack_bit} !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL midreset_values: got %b expected 000011",
               {busy, first_byte, ack_phase, shift_en, sda_sample, ack_bit});
    end
    scl_raw = 1'b1;
    sda_raw = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    s0 = shift_cnt; st0 = start_cnt;
    wait_clk(30);
    checks++;
    if (shift_cnt - s0 !== 0 || start_cnt - st0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got shifts %0d starts %0d busy %b expected 0 0 0",
               shift_cnt - s0, start_cnt - st0, busy);
    end
    test_first_byte();
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_final_stop: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_nack_stop();
    test_glitch();
    test_repeated_start();
    test_reset_mid_transfer();
    wait_clk(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
